instruction_loader: RTL and testbench

- Writer side of the instruction memory: receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words sequentially into the instruction memory write port, starting at word address 0.
- Holds the CPU in hold until a complete program image has been written.
- Sits between a byte source (UART receiver or testbench) and the instruction memory's write port.
- Stream format: 16-bit little-endian word count, then count×4 data bytes.

---
 rtl/instruction_loader.sv | 144 ++++++++++++++
 tb/tb_instruction_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Instruction-memory writer: takes a byte stream (16-bit LE word count, then LE words),
// writes the words sequentially from address 0 and holds the CPU until the image is complete.
module instruction_loader #(
  parameter int SIZE   = 64,
  parameter int ADDR_W = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [16:0] SIZE_EXT = 17'(SIZE);

  state_t              r_state, w_state_next;
  logic [15:0]         r_count, w_count_next;
  logic [15:0]         r_word_cnt, w_word_cnt_next;
  logic [1:0]          r_byte_idx, w_byte_idx_next;
  logic [23:0]         r_asm, w_asm_next;
  logic                r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0]   r_mem_a, w_mem_a_next;
  logic [31:0]         r_mem_wd, w_mem_wd_next;
  logic                r_err, w_err_next;

  logic                w_hs;
  logic [15:0]         w_count_full;
  logic [15:0]         w_word_inc;
  logic                w_in_mem;

  assign in_ready     = (r_state == S_CNT_LO) || (r_state == S_CNT_HI) || (r_state == S_DATA);
  assign w_hs         = in_valid && in_ready;
  assign w_count_full = {in_data, r_count[7:0]};
  assign w_word_inc   = r_word_cnt + 16'd1;
  // Words past the end of memory are still consumed, just never written.
  assign w_in_mem     = ({1'b0, r_word_cnt} < SIZE_EXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_word_cnt <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
      r_mem_we   <= 1'b0;
      r_mem_a    <= '0;
      r_mem_wd   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_word_cnt <= w_word_cnt_next;
      r_byte_idx <= w_byte_idx_next;
      r_asm      <= w_asm_next;
      r_mem_we   <= w_mem_we_next;
      r_mem_a    <= w_mem_a_next;
      r_mem_wd   <= w_mem_wd_next;
      r_err      <= w_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_word_cnt_next = r_word_cnt;
    w_byte_idx_next = r_byte_idx;
    w_asm_next      = r_asm;
    w_mem_we_next   = 1'b0;
    w_mem_a_next    = r_mem_a;
    w_mem_wd_next   = r_mem_wd;
    w_err_next      = r_err;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next    = S_CNT_LO;
          w_err_next      = 1'b0;
          w_count_next    = '0;
          w_word_cnt_next = '0;
          w_byte_idx_next = '0;
          w_asm_next      = '0;
        end
      end
      S_CNT_LO: begin
        if (w_hs) begin
          w_count_next = {8'd0, in_data};
          w_state_next = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (w_hs) begin
          w_count_next = w_count_full;
          w_err_next   = ({1'b0, w_count_full} > SIZE_EXT);
          w_state_next = (w_count_full == 16'd0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          w_byte_idx_next = r_byte_idx + 2'd1;
          case (r_byte_idx)
            2'd0: w_asm_next[7:0]   = in_data;
            2'd1: w_asm_next[15:8]  = in_data;
            2'd2: w_asm_next[23:16] = in_data;
            default: begin
              if (w_in_mem) begin
                w_mem_we_next = 1'b1;
                w_mem_a_next  = r_word_cnt[ADDR_W-1:0];
                w_mem_wd_next = {in_data, r_asm};
              end
              w_word_cnt_next = w_word_inc;
              if (w_word_inc == r_count) begin
                w_state_next = S_DONE;
              end
            end
          endcase
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign mem_we   = r_mem_we;
  assign mem_a    = r_mem_a;
  assign mem_wd   = r_mem_wd;
  assign err      = r_err;
  assign done     = (r_state == S_DONE);
  assign cpu_hold = (r_state != S_DONE);

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: images are serialised from word lists and the
// observed write pulses are compared against the list truncated to the memory size.
module tb_instruction_loader;

  localparam int TB_SIZE = 8;
  localparam int AW      = $clog2(TB_SIZE);

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] img_words[$];
  int          got_a[$];
  logic [31:0] got_wd[$];
  logic        got_done[$];
  int          got_cyc[$];

  instruction_loader #(.SIZE(TB_SIZE)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_a.push_back(int'(mem_a));
      got_wd.push_back(mem_wd);
      got_done.push_back(done);
      got_cyc.push_back(cyc);
    end
  end

  // Present one byte starting at a negedge; returns at the negedge after its handshake edge.
  task automatic send_byte(input logic [7:0] b, input int mode, input bit pulse_start, input string tag);
    if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
      in_valid = 1'b0;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s in_ready_gap: got %b want 1", tag, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = pulse_start;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready: got %b want 1", tag, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_load(input int cnt, input int mode, input int start_at, input string tag);
    logic [15:0] c16;
    logic [7:0]  b;
    int          idx;
    int          nexp;
    bit          exp_err;
    c16     = cnt[15:0];
    exp_err = (cnt > TB_SIZE);
    got_a.delete();
    got_wd.delete();
    got_done.delete();
    got_cyc.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || cpu_hold !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s after_start: got done=%b hold=%b err=%b want 0 1 0", tag, done, cpu_hold, err);
    end
    send_byte(c16[7:0], mode, 1'b0, tag);
    send_byte(c16[15:8], mode, 1'b0, tag);
    total++;
    if (err !== exp_err) begin
      bad++;
      $display("FAIL %s err_at_cnt: got %b want %b", tag, err, exp_err);
    end
    idx = 0;
    for (int w = 0; w < cnt; w++) begin
      for (int bi = 0; bi < 4; bi++) begin
        b = img_words[w][8*bi +: 8];
        send_byte(b, mode, (idx == start_at), tag);
        idx++;
      end
    end
    #1;
    total++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0 || err !== exp_err) begin
      bad++;
      $display("FAIL %s end_state: got done=%b hold=%b rdy=%b err=%b want 1 0 0 %b",
               tag, done, cpu_hold, in_ready, err, exp_err);
    end
    nexp = (cnt < TB_SIZE) ? cnt : TB_SIZE;
    total++;
    if (got_a.size() != nexp) begin
      bad++;
      $display("FAIL %s write_count: got %0d want %0d", tag, got_a.size(), nexp);
    end else begin
      for (int i = 0; i < nexp; i++) begin
        total++;
        if (got_a[i] != i || got_wd[i] !== img_words[i] || got_done[i] !== (i == cnt - 1)) begin
          bad++;
          $display("FAIL %s write%0d: got a=%0d wd=%08h done=%b want a=%0d wd=%08h done=%b",
                   tag, i, got_a[i], got_wd[i], got_done[i], i, img_words[i], (i == cnt - 1));
        end
        if (mode == 0 && i > 0) begin
          total++;
          if (got_cyc[i] - got_cyc[i-1] != 4) begin
            bad++;
            $display("FAIL %s spacing%0d: got %0d want 4", tag, i, got_cyc[i] - got_cyc[i-1]);
          end
        end
      end
    end
    $display("load %s: count=%0d writes=%0d err=%b", tag, cnt, got_a.size(), err);
  endtask

  task automatic rand_words(input int cnt);
    img_words.delete();
    for (int i = 0; i < cnt; i++) img_words.push_back($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (mem_we !== 1'b0 || mem_a !== '0 || mem_wd !== 32'd0 || in_ready !== 1'b0 ||
        cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got we=%b a=%0d wd=%08h rdy=%b hold=%b done=%b err=%b",
               mem_we, mem_a, mem_wd, in_ready, cpu_hold, done, err);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_outputs: got rdy=%b hold=%b done=%b want 0 1 0", in_ready, cpu_hold, done);
    end
    $display("reset checked");
  endtask

  task automatic test_basic;
    img_words.delete();
    img_words.push_back(32'h0010_0513);
    img_words.push_back(32'h0020_0593);
    run_load(2, 0, -1, "basic");
  endtask

  task automatic test_stall;
    img_words.delete();
    img_words.push_back(32'h0010_0513);
    img_words.push_back(32'h0020_0593);
    run_load(2, 1, -1, "stall");
  endtask

  task automatic test_zero;
    img_words.delete();
    run_load(0, 0, -1, "zero");
  endtask

  task automatic test_overflow;
    rand_words(TB_SIZE + 3);
    run_load(TB_SIZE + 3, 0, -1, "overflow");
  endtask

  task automatic test_reload;
    img_words.delete();
    img_words.push_back(32'h1234_5678);
    run_load(1, 0, -1, "reload");
  endtask

  task automatic test_start_in_data;
    rand_words(3);
    run_load(3, 0, 7, "start_in_data");
  endtask

  task automatic test_reset_mid;
    int n_before;
    rand_words(3);
    got_a.delete();
    got_wd.delete();
    got_done.delete();
    got_cyc.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'd3, 0, 1'b0, "reset_mid");
    send_byte(8'd0, 0, 1'b0, "reset_mid");
    for (int bi = 0; bi < 4; bi++) send_byte(img_words[0][8*bi +: 8], 0, 1'b0, "reset_mid");
    send_byte(img_words[1][7:0], 0, 1'b0, "reset_mid");
    send_byte(img_words[1][15:8], 0, 1'b0, "reset_mid");
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++;
    if (mem_we !== 1'b0 || mem_a !== '0 || mem_wd !== 32'd0 || in_ready !== 1'b0 ||
        cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got we=%b a=%0d wd=%08h rdy=%b hold=%b done=%b err=%b",
               mem_we, mem_a, mem_wd, in_ready, cpu_hold, done, err);
    end
    n_before = got_a.size();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (got_a.size() != n_before || n_before != 1) begin
      bad++;
      $display("FAIL reset_mid_writes: got %0d writes want 1", got_a.size());
    end
    $display("reset mid-load checked: writes=%0d", got_a.size());
    rand_words(2);
    run_load(2, 0, -1, "after_reset");
  endtask

  task automatic test_random;
    int cnt;
    for (int t = 0; t < 8; t++) begin
      cnt = $urandom_range(0, TB_SIZE + 3);
      rand_words(cnt);
      run_load(cnt, 2, -1, "random");
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_overflow();
    test_reload();
    test_start_in_data();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
